// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 set-2 keyboard FIFO driver.
package kbd_pkg;

   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_SLASH  = 8'h4A;

   localparam int unsigned SEQ_W = 14;

   localparam logic ADR_DATA = 1'b0;
   localparam logic ADR_STAT = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} kbd_state_e;

   typedef struct packed {
      logic [7:0]       ascii;
      logic [7:0]       scancode;
      logic             ext;
      logic [SEQ_W-1:0] seq;
   } kbd_entry_t;

endpackage

// File: rtl/kbd_fifo.sv
// Power-of-two synchronous FIFO with flush and occupancy count.
module kbd_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push, do_pop;

   assign full    = (level_q == FULL_LVL);
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem[rd_ptr_q];
   // A pop frees the slot, so a push into a full FIFO is legal in the same cycle.
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | pop) & ~flush;

   // Storage array; no reset needed since level gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      level_q <= level_q + 1'b1;
         else if (do_pop && !do_push) level_q <= level_q - 1'b1;
      end
   end

endmodule

// File: rtl/keyboard_fifo_driver.sv
// PS/2 set-2 decoder with shift tracking, ASCII translation, FIFO queue and bus slave.
module keyboard_fifo_driver
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned IRQ_LEVEL  = 1,
   parameter int unsigned ENABLE_EXT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ready_pulse,
   input  logic [7:0]  Keyboard_Data,
   input  logic        STB,
   input  logic        WE,
   input  logic        ADR,
   input  logic [31:0] DAT_I,
   output logic        ACK,
   output logic [31:0] DAT_O,
   output logic        irq
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] IRQ_LVL = LW'(IRQ_LEVEL);

   // US set-2 map; ascii 0 means unmapped.
   function automatic logic [7:0] us_map(input logic [7:0] sc, input logic shift);
      logic [7:0] a;
      case (sc)
         8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
         8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
         8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
         8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
         8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
         8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
         8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33; 8'h25: a = 8'h34;
         8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37; 8'h3E: a = 8'h38;
         8'h46: a = 8'h39; 8'h45: a = 8'h30;
         8'h4E: a = 8'h2D; 8'h55: a = 8'h2B; 8'h54: a = 8'h5B; 8'h5B: a = 8'h5D;
         8'h4C: a = 8'h3B; 8'h5D: a = 8'h5C; 8'h41: a = 8'h2C; 8'h49: a = 8'h2E;
         8'h4A: a = 8'h2F; 8'h29: a = 8'h20; 8'h66: a = 8'h08; 8'h5A: a = 8'h0A;
         default: a = 8'h00;
      endcase
      if (shift) begin
         if (a >= 8'h61 && a <= 8'h7A) a = a - 8'd32;
         else begin
            case (a)
               8'h31: a = 8'h21; 8'h32: a = 8'h40; 8'h33: a = 8'h23; 8'h34: a = 8'h24;
               8'h35: a = 8'h25; 8'h36: a = 8'h5E; 8'h37: a = 8'h26; 8'h38: a = 8'h2A;
               8'h39: a = 8'h28; 8'h30: a = 8'h29;
               default: ;
            endcase
         end
      end
      return a;
   endfunction

   kbd_state_e       state_q, state_d;
   logic             ready_q, byte_evt;
   logic             lshift_q, lshift_d, rshift_q, rshift_d, shift;
   logic             push_q, push_d, ext_q, ext_d;
   logic [7:0]       ascii_q, ascii_d, sc_q, sc_d;
   logic [SEQ_W-1:0] seq_q;
   logic             overflow_q, overflow_d;
   logic             ack_q, irq_q;
   logic [31:0]      dat_q, dat_d;
   logic             bus_req, rd_data, rd_stat, flush, pop, push_ok, ovf_set;
   logic             full, empty;
   logic [LW-1:0]    level;
   kbd_entry_t       head, tail;
   logic             unused_dat;

   assign byte_evt   = ready_pulse & ~ready_q;
   assign shift      = lshift_q | rshift_q;
   assign unused_dat = ^DAT_I[31:1];

   // Bus decode: a request is taken on the edge that raises ACK.
   assign bus_req = STB & ~ack_q;
   assign rd_data = bus_req & ~WE & (ADR == ADR_DATA);
   assign rd_stat = bus_req & ~WE & (ADR == ADR_STAT);
   assign flush   = bus_req & WE & (ADR == ADR_STAT) & DAT_I[0];
   assign pop     = rd_data & ~empty;
   assign push_ok = push_q & ~flush & (~full | pop);
   assign ovf_set = push_q & ~flush & full & ~pop;
   assign tail    = '{ascii: ascii_q, scancode: sc_q, ext: ext_q, seq: seq_q};

   // Scancode sequence decode, shift tracking and push staging.
   always_comb begin
      state_d  = state_q;
      lshift_d = lshift_q;
      rshift_d = rshift_q;
      push_d   = 1'b0;
      ascii_d  = ascii_q;
      sc_d     = sc_q;
      ext_d    = ext_q;
      if (byte_evt) begin
         unique case (state_q)
            S_IDLE: begin
               if (Keyboard_Data == SC_BRK)        state_d = S_BRK;
               else if (Keyboard_Data == SC_EXT)   state_d = S_EXT;
               else if (Keyboard_Data == SC_PAUSE || Keyboard_Data == SC_BAT) ;
               else if (Keyboard_Data == SC_LSHIFT) lshift_d = 1'b1;
               else if (Keyboard_Data == SC_RSHIFT) rshift_d = 1'b1;
               else begin
                  ascii_d = us_map(Keyboard_Data, shift);
                  sc_d    = Keyboard_Data;
                  ext_d   = 1'b0;
                  push_d  = (ascii_d != 8'h00);
               end
            end
            S_BRK: begin
               if (Keyboard_Data == SC_LSHIFT) lshift_d = 1'b0;
               if (Keyboard_Data == SC_RSHIFT) rshift_d = 1'b0;
               state_d = S_IDLE;
            end
            S_EXT: begin
               if (Keyboard_Data == SC_BRK) state_d = S_EXT_BRK;
               else begin
                  state_d = S_IDLE;
                  if (ENABLE_EXT != 0 &&
                      (Keyboard_Data == SC_ENTER || Keyboard_Data == SC_SLASH)) begin
                     ascii_d = (Keyboard_Data == SC_ENTER) ? 8'h0A : 8'h2F;
                     sc_d    = Keyboard_Data;
                     ext_d   = 1'b1;
                     push_d  = 1'b1;
                  end
               end
            end
            S_EXT_BRK: state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Bus read mux and sticky overflow next-state.
   always_comb begin
      dat_d      = 32'h0;
      overflow_d = overflow_q;
      if (rd_data && !empty) dat_d = {head.ascii, head.scancode, 1'b1, head.ext, head.seq};
      if (rd_stat) dat_d = {overflow_q, shift, 14'b0, {(16 - LW){1'b0}}, level};
      if (flush)        overflow_d = 1'b0;
      else if (ovf_set) overflow_d = 1'b1;
      else if (rd_stat) overflow_d = 1'b0;
   end

   // All control state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b0;
         lshift_q   <= 1'b0;
         rshift_q   <= 1'b0;
         push_q     <= 1'b0;
         ascii_q    <= 8'h00;
         sc_q       <= 8'h00;
         ext_q      <= 1'b0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= 32'h0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_pulse;
         lshift_q   <= lshift_d;
         rshift_q   <= rshift_d;
         push_q     <= push_d;
         ascii_q    <= ascii_d;
         sc_q       <= sc_d;
         ext_q      <= ext_d;
         if (push_ok) seq_q <= seq_q + 1'b1;
         overflow_q <= overflow_d;
         ack_q      <= bus_req;
         dat_q      <= dat_d;
         irq_q      <= (level >= IRQ_LVL);
      end
   end

   kbd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(kbd_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop),
      .flush (flush),
      .wdata (tail),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign ACK   = ack_q;
   assign DAT_O = dat_q;
   assign irq   = irq_q;

endmodule

// File: tb/tb_keyboard_fifo_driver.sv
// Directed bench: DUT 0 is DEPTH 16 / IRQ_LEVEL 1 / ext on, DUT 1 is DEPTH 4 / IRQ_LEVEL 2 / ext off.
module tb_keyboard_fifo_driver;

   logic        clk;
   logic        reset;
   logic        rp   [2];
   logic [7:0]  kd   [2];
   logic        stb  [2];
   logic        we   [2];
   logic        adr  [2];
   logic [31:0] dati [2];
   logic        ack  [2];
   logic [31:0] dato [2];
   logic        irq  [2];

   int nvec = 0;
   int nerr = 0;
   logic [31:0] rd;

   keyboard_fifo_driver #(.DEPTH(16), .IRQ_LEVEL(1), .ENABLE_EXT(1)) dut0 (
      .clk(clk), .reset(reset), .ready_pulse(rp[0]), .Keyboard_Data(kd[0]),
      .STB(stb[0]), .WE(we[0]), .ADR(adr[0]), .DAT_I(dati[0]),
      .ACK(ack[0]), .DAT_O(dato[0]), .irq(irq[0])
   );

   keyboard_fifo_driver #(.DEPTH(4), .IRQ_LEVEL(2), .ENABLE_EXT(0)) dut1 (
      .clk(clk), .reset(reset), .ready_pulse(rp[1]), .Keyboard_Data(kd[1]),
      .STB(stb[1]), .WE(we[1]), .ADR(adr[1]), .DAT_I(dati[1]),
      .ACK(ack[1]), .DAT_O(dato[1]), .irq(irq[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rp[i] = 0; kd[i] = 8'h00; stb[i] = 0; we[i] = 0; adr[i] = 0; dati[i] = 32'h0;
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   // Returns one cycle after the push lands, so irq has settled.
   task automatic send_byte(input int d, input logic [7:0] b);
      @(posedge clk); #1;
      rp[d] = 1'b1; kd[d] = b;
      @(posedge clk); #1;
      rp[d] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
   endtask

   task automatic bus_cycle(input int d, input logic w, input logic a, input logic [31:0] wd,
                            output logic [31:0] data);
      logic got;
      got = 1'b0;
      data = 32'h0;
      @(posedge clk); #1;
      stb[d] = 1'b1; we[d] = w; adr[d] = a; dati[d] = wd;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         if (ack[d]) begin
            got = 1'b1;
            data = dato[d];
         end
      end
      stb[d] = 1'b0; we[d] = 1'b0;
      check("ack_seen", {31'b0, got}, 32'd1);
   endtask

   initial begin
      do_reset();
      check("rst_ack0", {31'b0, ack[0]}, 32'd0);
      check("rst_dat0", dato[0], 32'h0);
      check("rst_irq0", {31'b0, irq[0]}, 32'd0);
      check("rst_irq1", {31'b0, irq[1]}, 32'd0);

      // Plain make/break of 'a'.
      send_byte(0, 8'h1C); send_byte(0, 8'hF0); send_byte(0, 8'h1C);
      check("a_irq", {31'b0, irq[0]}, 32'd1);
      bus_cycle(0, 0, 0, 0, rd);
      check("a_read", rd, 32'h611C8000);
      @(posedge clk); #1;
      check("dat_idle", dato[0], 32'h0);
      check("irq_drop", {31'b0, irq[0]}, 32'd0);
      bus_cycle(0, 0, 0, 0, rd);
      check("empty_read", rd, 32'h0);

      // Shifted letters and digit.
      do_reset();
      send_byte(0, 8'h12);
      bus_cycle(0, 0, 1, 0, rd);
      check("stat_shift", rd, 32'h40000000);
      send_byte(0, 8'h1C); send_byte(0, 8'hF0); send_byte(0, 8'h1C);
      send_byte(0, 8'hF0); send_byte(0, 8'h12); send_byte(0, 8'h1C);
      bus_cycle(0, 0, 0, 0, rd);
      check("A_read", rd, 32'h411C8000);
      bus_cycle(0, 0, 0, 0, rd);
      check("a2_read", rd, 32'h611C8001);
      bus_cycle(0, 0, 1, 0, rd);
      check("stat_noshift", rd, 32'h0);
      send_byte(0, 8'h12); send_byte(0, 8'h16); send_byte(0, 8'hF0);
      send_byte(0, 8'h16); send_byte(0, 8'hF0); send_byte(0, 8'h12);
      bus_cycle(0, 0, 0, 0, rd);
      check("bang_read", rd, 32'h21168002);

      // Overflow on the DEPTH 4 instance, irq threshold 2.
      do_reset();
      send_byte(1, 8'h16);
      check("irq_below", {31'b0, irq[1]}, 32'd0);
      send_byte(1, 8'h16);
      check("irq_at", {31'b0, irq[1]}, 32'd1);
      for (int i = 0; i < 4; i++) send_byte(1, 8'h16);
      for (int i = 0; i < 4; i++) begin
         bus_cycle(1, 0, 0, 0, rd);
         check("ovf_read", rd, 32'h31168000 | i);
      end
      bus_cycle(1, 0, 1, 0, rd);
      check("ovf_stat1", rd, 32'h80000000);
      bus_cycle(1, 0, 1, 0, rd);
      check("ovf_stat2", rd, 32'h0);
      send_byte(1, 8'h1C);
      bus_cycle(1, 0, 0, 0, rd);
      check("seq_after_ovf", rd, 32'h611C8004);

      // Extended makes: kept on DUT 0, dropped on DUT 1.
      do_reset();
      send_byte(0, 8'hE0); send_byte(0, 8'h5A);
      send_byte(0, 8'hE0); send_byte(0, 8'hF0); send_byte(0, 8'h5A);
      send_byte(1, 8'hE0); send_byte(1, 8'h5A);
      send_byte(1, 8'hE0); send_byte(1, 8'hF0); send_byte(1, 8'h5A);
      bus_cycle(0, 0, 0, 0, rd);
      check("ext_enter", rd, 32'h0A5AC000);
      bus_cycle(0, 0, 0, 0, rd);
      check("ext_once", rd, 32'h0);
      bus_cycle(1, 0, 0, 0, rd);
      check("ext_off", rd, 32'h0);
      send_byte(0, 8'hE0); send_byte(0, 8'h4A);
      send_byte(0, 8'h05);
      send_byte(0, 8'hE1); send_byte(0, 8'h1C);
      bus_cycle(0, 0, 0, 0, rd);
      check("ext_slash", rd, 32'h2F4AC001);
      bus_cycle(0, 0, 0, 0, rd);
      check("e1_skip", rd, 32'h611C8002);

      // Held strobe is one event only.
      @(posedge clk); #1; rp[0] = 1'b1; kd[0] = 8'h32;
      repeat (4) @(posedge clk);
      #1; rp[0] = 1'b0;
      repeat (2) @(posedge clk);
      bus_cycle(0, 0, 1, 0, rd);
      check("held_level", rd, 32'h00000001);

      // Full FIFO: pop and push land on the same edge.
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(1, 8'h16);
      @(posedge clk); #1; rp[1] = 1'b1; kd[1] = 8'h1C;
      @(posedge clk); #1; rp[1] = 1'b0; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 1'b0;
      @(posedge clk); #1;
      check("coin_ack", {31'b0, ack[1]}, 32'd1);
      check("coin_dat", dato[1], 32'h31168000);
      stb[1] = 1'b0;
      bus_cycle(1, 0, 1, 0, rd);
      check("coin_stat", rd, 32'h00000004);
      for (int i = 1; i < 4; i++) begin
         bus_cycle(1, 0, 0, 0, rd);
         check("coin_read", rd, 32'h31168000 | i);
      end
      bus_cycle(1, 0, 0, 0, rd);
      check("coin_tail", rd, 32'h611C8004);

      // Reset after a break prefix, then flush.
      do_reset();
      send_byte(0, 8'hF0);
      do_reset();
      send_byte(0, 8'h1C);
      bus_cycle(0, 0, 0, 0, rd);
      check("rst_mid", rd, 32'h611C8000);
      send_byte(0, 8'h1C); send_byte(0, 8'h32);
      bus_cycle(0, 1, 1, 32'h0, rd);
      bus_cycle(0, 0, 1, 0, rd);
      check("nop_write", rd, 32'h00000002);
      bus_cycle(0, 1, 1, 32'h1, rd);
      check("flush_irq_hold", {31'b0, irq[0]}, 32'd1);
      @(posedge clk); #1;
      check("flush_irq_drop", {31'b0, irq[0]}, 32'd0);
      bus_cycle(0, 0, 1, 0, rd);
      check("flush_stat", rd, 32'h0);
      bus_cycle(0, 0, 0, 0, rd);
      check("flush_empty", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/keyboard_fifo_driver.md
Name: keyboard_fifo_driver

Overview:
Clock-synchronous successor to the single-register PS/2 scancode driver. Decodes set-2 make/break/extended sequences with an explicit FSM and tracks Shift. Translates make codes to ASCII, upper-casing letters and the digit row when Shift is held. Queues results in a parametrised FIFO read through the CPU bus slave port (STB/ACK) and raises a level interrupt.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
IRQ_LEVEL, 1, FIFO occupancy at or above which irq asserts; 1..DEPTH
ENABLE_EXT, 1, 1 = enqueue E0-prefixed keypad Enter/slash; 0 = drop all extended makes

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ready_pulse  in  1  scancode strobe from PS/2 receiver, clk-synchronous; act on its rising edge only
Keyboard_Data  in  8  scancode byte, valid while ready_pulse high
STB  in  1  bus strobe; held until ACK
WE  in  1  bus write enable
ADR  in  1  0 = data register, 1 = status/control register
DAT_I  in  32  bus write data
ACK  out  1  single-cycle registered acknowledge
DAT_O  out  32  read data, valid in ACK cycle
irq  out  1  level interrupt, occupancy >= IRQ_LEVEL

Behaviour:
- Reset (reset=0, async): FSM S_IDLE, FIFO empty, level 0, overflow 0, shift 0, seq 0, ACK 0, DAT_O 0, irq 0.
- Byte event: ready_pulse high and previous-cycle ready_pulse low. One byte per event; a held strobe is not re-accepted.
- FSM: S_IDLE: F0->S_BRK; E0->S_EXT; else make. S_EXT: F0->S_EXT_BRK; else extended make, ->S_IDLE. S_BRK, S_EXT_BRK: next byte is break, ->S_IDLE. Byte E1 or AA in S_IDLE is ignored.
- Shift: make 12 or 59 sets lshift/rshift; matching break clears it. shift = lshift|rshift. Modifier codes are never enqueued.
- Translation uses the existing US map (digits, letters, - + [ ] ; \ , . / space, 66->08, 5A->0A). With shift: a-z map to A-Z (minus 32); 1..0 map to ! @ # $ % ^ & * ( ). All other codes are unchanged. Unmapped code (ascii 0) is dropped.
- Extended make, ENABLE_EXT=1: E0 5A->0A, E0 4A->2F. All other extended makes are dropped.
- Enqueue entry = {ascii[7:0], scancode[7:0], ext}. It is pushed the cycle after the byte event. seq increments (14-bit wrap) on every accepted push only.
- Full: push dropped, overflow set (sticky), seq unchanged. Simultaneous pop and push when full: both occur, level unchanged, no overflow.
- Bus: ACK <= STB & ~ACK, so a held STB gives a one-cycle ACK every other cycle. DAT_O is registered with ACK and is 0 when ACK is low.
- Read ADR=0: DAT_O = {ascii, scancode, valid, ext, seq_at_push[13:0]}. Non-empty: valid=1 and the head is popped in the ACK cycle. Empty: DAT_O = 0 and nothing is popped.
- Read ADR=1: DAT_O = {overflow, shift, 14'b0, 16-bit level}. Overflow clears in the ACK cycle. If a new overflow occurs in that same cycle, set wins.
- Write ADR=1 with DAT_I[0]=1: FIFO flushed (level 0) and overflow cleared. A push in the same cycle is discarded. All other writes are acked and ignored.
- irq = registered (level >= IRQ_LEVEL). It updates the cycle after a level change.
- Reset mid-sequence (e.g. after F0) returns to S_IDLE; the next byte is treated as a make.

Decomposition:
- Package kbd_pkg: scancode constants (F0, E0, LSHIFT 12, RSHIFT 59), FSM state enum, entry struct/field widths, address constants.
- Sub-module kbd_fifo: DEPTH-parameterised synchronous FIFO with push/pop/flush, full/empty, level. The translation table is a combinational function in the top module.

Test Plan:
- Bytes 1C, F0 1C -> one entry; read ADR0 gives DAT_O = {8'h61, 8'h1C, 1, 0, seq 0}. A second read returns 32'h0.
- Bytes 12, 1C, F0 1C, F0 12, 1C -> entries 'A' (41) then 'a' (61), seq 0 and 1. Status shift=0 at end.
- DEPTH=4: six makes of 16 without a read -> level 4, overflow=1, irq=1. Four reads give '1' with seq 0..3. A status read returns overflow=1; the next status read returns 0.
- E0 5A then E0 F0 5A, ENABLE_EXT=1 -> one entry {0A, 5A, ext=1}. Same with ENABLE_EXT=0 -> no entry.
- Full FIFO with a data read ACK coinciding with a push -> level stays DEPTH, overflow stays 0, new entry at tail.
- Assert reset after F0 has been sent, then send 1C -> entry 'a' enqueued (not treated as a break). Flush write with DAT_I=1 -> level 0, irq deasserts the next cycle.
